// File: rtl/adder_fp.sv
// adder_fp: multi-cycle binary32 adder/subtractor with start/busy/ready handshake
module adder_fp (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        ready,
    output logic [31:0] Y
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, DONE} state_t;
    state_t st, nxt;
    logic [31:0] ra, rb, spv, spc, y_c;
    logic        rop, sp, spf, sg, sub;
    logic [7:0]  el, d, ea, eb, ea_e, eb_e;
    logic [26:0] ml, ms, al, al_c, n, n_c, ga, gb;
    logic [27:0] s, s_c;
    logic [9:0]  ne, e_c, e2;
    logic [4:0]  lz;
    logic [24:0] mr;
    logic        za, zb, ia, ib, na, nb, sa, sb, age, up;
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else st <= nxt;
    // sequencing and handshake outputs
    always_comb begin
        nxt = st == IDLE ? (start ? UNPACK : IDLE) : st == DONE ? IDLE : state_t'(st + 3'd1);
        busy = st != IDLE && st != DONE;
        ready = st == DONE;
    end
    // decode operands, special-case result and magnitude ordering
    always_comb begin
        ea = ra[30:23];
        eb = rb[30:23];
        za = ea == 8'd0;
        zb = eb == 8'd0;
        ia = &ea && ra[22:0] == 23'd0;
        ib = &eb && rb[22:0] == 23'd0;
        na = &ea && |ra[22:0];
        nb = &eb && |rb[22:0];
        sa = ra[31];
        sb = rb[31] ^ rop;
        ea_e = za ? 8'd0 : ea;
        eb_e = zb ? 8'd0 : eb;
        ga = za ? 27'd0 : {1'b1, ra[22:0], 3'b000};
        gb = zb ? 27'd0 : {1'b1, rb[22:0], 3'b000};
        age = (za ? 31'd0 : ra[30:0]) >= (zb ? 31'd0 : rb[30:0]);
        spf = na | nb | ia | ib | (za & zb);
        spc = (na | nb | (ia & ib & (sa ^ sb))) ? 32'h7FC0_0000 :
              ia ? {sa, 31'h7F80_0000} : ib ? {sb, 31'h7F80_0000} : {sa & sb, 31'd0};
    end
    // align, add/subtract and normalize the magnitudes
    always_comb begin
        al_c = (ms >> d) | {26'd0, |(ms & ~({27{1'b1}} << d))};
        s_c = sub ? {1'b0, ml} - {1'b0, al} : {1'b0, ml} + {1'b0, al};
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (s[i]) lz = 5'(26 - i);
        n_c = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0] << lz;
        e_c = s[27] ? {2'b00, el} + 10'd1 : {2'b00, el} - {5'd0, lz};
    end
    // round to nearest even and pack with underflow/overflow handling
    always_comb begin
        up = n[2] & (n[1] | n[0] | n[3]);
        mr = {1'b0, n[26:3]} + {24'd0, up};
        e2 = ne + {9'd0, mr[24]};
        y_c = n == 27'd0 ? 32'd0 :
              (e2[9] || e2 == 10'd0) ? {sg, 31'd0} :
              (e2 >= 10'd255) ? {sg, 8'hFF, 23'd0} :
              {sg, e2[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    end
    // per-stage pipeline registers and result register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ra <= '0; rb <= '0; rop <= 1'b0;
            sp <= 1'b0; spv <= '0; sg <= 1'b0; sub <= 1'b0;
            el <= '0; ml <= '0; ms <= '0; d <= '0;
            al <= '0; s <= '0; n <= '0; ne <= '0; Y <= '0;
        end else begin
            if (st == IDLE && start) begin
                ra <= A; rb <= B; rop <= op;
            end
            if (st == UNPACK) begin
                sp <= spf;
                spv <= spc;
                sg <= age ? sa : sb;
                sub <= sa ^ sb;
                el <= age ? ea_e : eb_e;
                ml <= age ? ga : gb;
                ms <= age ? gb : ga;
                d <= age ? ea_e - eb_e : eb_e - ea_e;
            end
            if (st == ALIGN) al <= al_c;
            if (st == ADDSUB) s <= s_c;
            if (st == NORM) begin
                n <= n_c;
                ne <= e_c;
            end
            if (st == ROUND) Y <= sp ? spv : y_c;
        end
endmodule

// File: tb/tb_adder_fp.sv
// tb_adder_fp: exact-arithmetic reference model plus directed vectors for adder_fp
module tb_adder_fp;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0;
    logic [31:0] A = '0, B = '0, Y;
    logic        busy, ready;
    int          checks = 0, fails = 0, ph = -1;
    logic [31:0] pend = '0, hold = '0;

    adder_fp dut (.clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
                  .busy(busy), .ready(ready), .Y(Y));

    always #5 clk = ~clk;

    // reference: exact sum in a wide integer, then round-to-nearest-even
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic o);
        logic [299:0] va, vb, mag, q, rem, half;
        int ea, eb, em, p, k, e;
        logic sa, sb, s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = a[31];
        sb = b[31] ^ o;
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
        if (ea == 255 && eb == 255 && sa != sb) return 32'h7FC0_0000;
        if (ea == 255) return {sa, 31'h7F80_0000};
        if (eb == 255) return {sb, 31'h7F80_0000};
        if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
        va = (ea == 0) ? 300'd0 : {276'd0, 1'b1, a[22:0]};
        vb = (eb == 0) ? 300'd0 : {276'd0, 1'b1, b[22:0]};
        em = (ea == 0) ? eb : (eb == 0) ? ea : (ea < eb ? ea : eb);
        if (ea != 0) va = va << (ea - em);
        if (eb != 0) vb = vb << (eb - em);
        if (sa == sb) begin mag = va + vb; s = sa; end
        else if (va >= vb) begin mag = va - vb; s = sa; end
        else begin mag = vb - va; s = sb; end
        if (mag == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p + em - 23;
        if (p > 23) begin
            k = p - 23;
            q = mag >> k;
            rem = mag - (q << k);
            half = 300'd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end else q = mag << (23 - p);
        if (q[24]) begin q = q >> 1; e = e + 1; end
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(e), q[22:0]};
    endfunction

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // timing/result expectation: capture starts a 6-cycle window, result lands on the 6th
    always @(posedge clk or posedge rst)
        if (rst) begin
            ph <= -1;
            hold <= '0;
        end else if (ph < 0) begin
            if (start) begin
                ph <= 0;
                pend <= model(A, B, op);
            end
        end else if (ph == 4) begin
            ph <= 5;
            hold <= pend;
        end else if (ph == 5) ph <= -1;
        else ph <= ph + 1;

    always @(negedge clk) begin
        check(32'(busy), 32'(ph >= 0 && ph <= 4), "busy");
        check(32'(ready), 32'(ph == 5), "ready");
        check(Y, hold, "y_model");
    end

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic o,
                       input logic [31:0] e, input string nm);
        int cyc, bc;
        check(model(a, b, o), e, {nm, "_model"});
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; op = ~o;
        cyc = 1;
        bc = busy ? 1 : 0;
        while (!ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy) bc++;
        end
        check(32'(cyc), 32'd6, {nm, "_latency"});
        check(32'(bc), 32'd5, {nm, "_busy_cycles"});
        check(Y, e, nm);
        @(negedge clk);
    endtask

    initial begin
        int rc;
        @(negedge clk);
        check(Y, 32'd0, "reset_y");
        check(32'(busy), 32'd0, "reset_busy");
        @(negedge clk);
        #2 rst = 1'b0;
        run(32'h40C00000, 32'h40200000, 1'b0, 32'h41080000, "add_6_2p5");
        run(32'h40C00000, 32'h40200000, 1'b1, 32'h40600000, "sub_6_2p5");
        run(32'h12B218AF, 32'h1EC22880, 1'b0, 32'h1EC22881, "sticky_up");
        run(32'h92B218AF, 32'h1EC22880, 1'b1, 32'h9EC22881, "neg_sub");
        run(32'h7F800000, 32'h1EC22880, 1'b0, 32'h7F800000, "inf");
        run(32'h3FC00001, 32'h1EC22880, 1'b0, 32'h3FC00001, "absorb");
        run(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, "cancel");
        run(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, "inf_minus_inf");
        run(32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, "nan");
        run(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, "neg_zero");
        run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, "overflow");
        run(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, "tie_even");
        run(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, "tie_up");
        run(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, "underflow");
        @(negedge clk);
        A = 32'h40C00000; B = 32'h40200000; op = 1'b0; start = 1'b1;
        rc = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) op = 1'b1;
            if (i == 8) start = 1'b0;
            if (ready) rc++;
        end
        check(32'(rc), 32'd2, "held_start_pulses");
        check(Y, 32'h40600000, "held_start_y");
        @(negedge clk);
        A = 32'h40C00000; B = 32'h40200000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check(32'(busy), 32'd0, "abort_busy");
        check(32'(ready), 32'd0, "abort_ready");
        check(Y, 32'd0, "abort_y");
        #2 rst = 1'b0;
        rc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) rc++;
        end
        check(32'(rc), 32'd0, "abort_no_ready");
        check(Y, 32'd0, "abort_y_held");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
